// File: rtl/hamming_dec_sched.sv
// Round-robin scheduler sharing one Hamming decode core between NREQ requesters.
// Start/done sequencing with watchdog, tagged responses and saturating statistics.
module hamming_dec_sched #(
    parameter int NREQ    = 2,
    parameter int CW_W    = 38,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*CW_W-1:0]     req_cw,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [1:0]               rsp_err,
    output logic                     core_start,
    output logic [CW_W-1:0]          core_cw,
    input  logic                     core_done,
    input  logic [DATA_W-1:0]        core_data,
    input  logic                     core_no_error,
    input  logic                     clear_stats,
    output logic [15:0]              corr_cnt,
    output logic [7:0]               tmo_cnt,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int TW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    id_q, id_d;
    logic [CW_W-1:0]   cw_q, cw_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        err_q, err_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [15:0]       corr_q, corr_d;
    logic [7:0]        tmo_q, tmo_d;

    logic              gnt_found;
    logic [IDW-1:0]    gnt_idx;
    logic [IDW-1:0]    cand;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign req_ready = (state_q == IDLE && gnt_found)
                       ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cw_d    = cw_q;
        data_d  = data_q;
        err_d   = err_q;
        timer_d = timer_q;
        corr_d  = corr_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_found) begin
                    cw_d    = req_cw[int'(gnt_idx)*CW_W +: CW_W];
                    id_d    = gnt_idx;
                    ptr_d   = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    data_d  = core_data;
                    err_d   = core_no_error ? 2'b00 : 2'b01;
                    state_d = RESP;
                end else if (timer_q == TW'(TIMEOUT-1)) begin
                    data_d  = '0;
                    err_d   = 2'b10;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (err_q == 2'b01 && corr_q != '1) corr_d = corr_q + 16'd1;
                    if (err_q == 2'b10 && tmo_q != '1)  tmo_d  = tmo_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_stats) begin
            corr_d = '0;
            tmo_d  = '0;
        end
    end

    always_ff @(negedge clk) begin
        if (!rstb) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cw_q    <= '0;
            data_q  <= '0;
            err_q   <= '0;
            timer_q <= '0;
            corr_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cw_q    <= cw_d;
            data_q  <= data_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            corr_q  <= corr_d;
            tmo_q   <= tmo_d;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign core_start = (state_q == LAUNCH);
    assign busy       = (state_q != IDLE);
    assign core_cw    = cw_q;
    assign rsp_id     = id_q;
    assign rsp_data   = data_q;
    assign rsp_err    = err_q;
    assign corr_cnt   = corr_q;
    assign tmo_cnt    = tmo_q;

endmodule

// File: tb/tb_hamming_dec_sched.sv
// Bench for hamming_dec_sched: directed scenarios plus randomized transactions
// checked against a transaction-level model of grant order, latency and statistics.
module tb_hamming_dec_sched;

    localparam int NREQ = 2;
    localparam int CW_W = 38;
    localparam int TMO  = 64;

    logic              clk = 1'b0;
    logic              rstb;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*CW_W-1:0] req_cw;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [0:0]        rsp_id;
    logic [31:0]       rsp_data;
    logic [1:0]        rsp_err;
    logic              core_start;
    logic [CW_W-1:0]   core_cw;
    logic              core_done;
    logic [31:0]       core_data;
    logic              core_no_error;
    logic              clear_stats;
    logic [15:0]       corr_cnt;
    logic [7:0]        tmo_cnt;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int m_ptr   = 0;
    int m_corr  = 0;
    int m_tmo   = 0;

    hamming_dec_sched #(.NREQ(NREQ), .CW_W(CW_W), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstb(rstb),
        .req_valid(req_valid), .req_ready(req_ready), .req_cw(req_cw),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .core_start(core_start), .core_cw(core_cw), .core_done(core_done),
        .core_data(core_data), .core_no_error(core_no_error),
        .clear_stats(clear_stats), .corr_cnt(corr_cnt), .tmo_cnt(tmo_cnt),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // DUT updates on the falling edge; the bench drives and samples after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input logic [NREQ-1:0] vm);
        for (int k = 0; k < NREQ; k++)
            if (vm[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    // One full transaction starting in an IDLE cycle; dly=0 means the core never answers.
    task automatic txn(input logic [1:0] vm, input int dly, input int stall, input bit clr,
                       input logic [31:0] d, input bit ne);
        int id, last;
        bit bad;
        logic [CW_W-1:0] cw;
        logic [31:0] ed;
        logic [1:0]  ee, eg;
        for (int r = 0; r < NREQ; r++)
            req_cw[r*CW_W +: CW_W] = {6'($urandom), 32'($urandom)};
        req_valid = vm;
        #1;
        id = pick(vm);
        cw = req_cw[id*CW_W +: CW_W];
        eg = 2'(1 << id);
        chk("grant", {62'd0, req_ready}, {62'd0, eg});
        m_ptr = (id + 1) % NREQ;
        tick();
        chk("start", {63'd0, core_start}, 64'd1);
        chk("core_cw", {26'd0, core_cw}, {26'd0, cw});
        last = (dly > 0) ? 2 + dly : TMO + 2;
        bad = 1'b0;
        for (int c = 2; c < last; c++) begin
            tick();
            core_done     = (dly > 0 && c == 1 + dly);
            core_data     = core_done ? d : $urandom;
            core_no_error = ne;
            #1;
            if (rsp_valid !== 1'b0 || core_start !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1)
                bad = 1'b1;
        end
        chk("wait_phase", {63'd0, bad}, 64'd0);
        tick();
        core_done   = 1'b0;
        ed          = (dly > 0) ? d : 32'd0;
        ee          = (dly > 0) ? (ne ? 2'b00 : 2'b01) : 2'b10;
        rsp_ready   = (stall == 0);
        clear_stats = clr && (stall == 0);
        #1;
        chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("rsp_id", {63'd0, rsp_id}, 64'(id));
        chk("rsp_data", {32'd0, rsp_data}, {32'd0, ed});
        chk("rsp_err", {62'd0, rsp_err}, {62'd0, ee});
        chk("rsp_req_ready", {62'd0, req_ready}, 64'd0);
        bad = 1'b0;
        for (int s = 1; s <= stall; s++) begin
            tick();
            if (s == stall) begin
                rsp_ready   = 1'b1;
                clear_stats = clr;
            end
            #1;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'(id) || rsp_data !== ed ||
                rsp_err !== ee || req_ready !== 2'b00 || busy !== 1'b1)
                bad = 1'b1;
        end
        if (stall > 0) chk("resp_hold", {63'd0, bad}, 64'd0);
        if (clr) begin
            m_corr = 0;
            m_tmo  = 0;
        end else if (ee == 2'b01) begin
            m_corr = (m_corr == 65535) ? 65535 : m_corr + 1;
        end else if (ee == 2'b10) begin
            m_tmo = (m_tmo == 255) ? 255 : m_tmo + 1;
        end
        tick();
        rsp_ready   = 1'b0;
        clear_stats = 1'b0;
        req_valid   = '0;
        #1;
        chk("post_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("corr_cnt", {48'd0, corr_cnt}, 64'(m_corr));
        chk("tmo_cnt", {56'd0, tmo_cnt}, 64'(m_tmo));
    endtask

    initial begin
        rstb = 1'b0; req_valid = '0; req_cw = '0; rsp_ready = 1'b0;
        core_done = 1'b0; core_data = '0; core_no_error = 1'b0; clear_stats = 1'b0;
        tick();
        tick();
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_start", {63'd0, core_start}, 64'd0);
        chk("rst_cw", {26'd0, core_cw}, 64'd0);
        chk("rst_data", {32'd0, rsp_data}, 64'd0);
        chk("rst_corr", {48'd0, corr_cnt}, 64'd0);
        chk("rst_tmo", {56'd0, tmo_cnt}, 64'd0);
        rstb = 1'b1;

        txn(2'b01, 3, 0, 1'b0, 32'h1234_5678, 1'b1);
        for (int i = 0; i < 4; i++) txn(2'b11, 2, 0, 1'b0, $urandom, 1'b1);
        txn(2'b01, 2, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        txn(2'b10, 2, 10, 1'b0, $urandom, 1'b0);
        txn(2'b01, 1, 2, 1'b1, $urandom, 1'b0);
        txn(2'b01, 4, 0, 1'b0, $urandom, 1'b0);

        txn(2'b01, 0, 0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        tick();
        core_done = 1'b1; core_data = 32'hFFFF_0000; core_no_error = 1'b0;
        tick();
        core_done = 1'b0;
        #1;
        chk("late_done_busy", {63'd0, busy}, 64'd0);
        chk("late_done_rsp", {63'd0, rsp_valid}, 64'd0);
        tick();
        chk("late_done_tmo", {56'd0, tmo_cnt}, 64'(m_tmo));

        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        #1;
        m_ptr = 0; m_corr = 0; m_tmo = 0;
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_start", {63'd0, core_start}, 64'd0);
        chk("mid_rst_cw", {26'd0, core_cw}, 64'd0);
        chk("mid_rst_err", {62'd0, rsp_err}, 64'd0);
        chk("mid_rst_corr", {48'd0, corr_cnt}, 64'd0);
        chk("mid_rst_tmo", {56'd0, tmo_cnt}, 64'd0);
        txn(2'b11, 2, 0, 1'b0, $urandom, 1'b1);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] vm;
            int dly;
            vm  = 2'($urandom_range(1, 3));
            dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 8);
            txn(vm, dly, $urandom_range(0, 3), ($urandom_range(0, 15) == 0),
                $urandom, 1'($urandom_range(0, 1)));
        end

        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        #1;
        m_corr = 0; m_tmo = 0;
        chk("idle_clear_corr", {48'd0, corr_cnt}, 64'd0);
        chk("idle_clear_tmo", {56'd0, tmo_cnt}, 64'd0);
        for (int i = 0; i < 257; i++) txn(2'b01, 0, 0, 1'b0, 32'h0, 1'b0);
        chk("tmo_saturated", {56'd0, tmo_cnt}, 64'd255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
